// File: rtl/br_resolve_unit_if.sv
// Bundles the branch CDB, dispatch allocation, commit handshake and redirect/perf
// signals of br_resolve_unit. The slave modport is the resolve unit's own view.
interface br_resolve_unit_if #(
  parameter int ROB_DEPTH = 16
);
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  logic                 br_cdb_valid;
  logic [ROB_IDX_W-1:0] br_cdb_rob_id;
  logic                 br_cdb_miss_predict;
  logic [31:0]          br_cdb_target_address;
  logic                 alloc_valid;
  logic [ROB_IDX_W-1:0] alloc_rob_id;
  logic                 commit_valid;
  logic [ROB_IDX_W-1:0] commit_rob_id;
  logic                 commit_ready;
  logic                 backend_flush;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic [31:0]          perf_br_commit_cnt;
  logic [31:0]          perf_flush_cnt;

  modport master (
    output br_cdb_valid, br_cdb_rob_id, br_cdb_miss_predict, br_cdb_target_address,
    output alloc_valid, alloc_rob_id, commit_valid, commit_rob_id,
    input  commit_ready, backend_flush, redirect_valid, redirect_pc,
    input  perf_br_commit_cnt, perf_flush_cnt
  );

  modport slave (
    input  br_cdb_valid, br_cdb_rob_id, br_cdb_miss_predict, br_cdb_target_address,
    input  alloc_valid, alloc_rob_id, commit_valid, commit_rob_id,
    output commit_ready, backend_flush, redirect_valid, redirect_pc,
    output perf_br_commit_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/br_resolve_unit.sv
// Branch resolution table fed by the branch CDB; gates branch retirement at the
// ROB head and turns a committed mispredict into a flush/redirect plus recovery.
module br_resolve_unit #(
  parameter int ROB_DEPTH      = 16,
  parameter int RECOVER_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  br_resolve_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, RECOVER = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             rcnt_q, rcnt_d;
  logic [ROB_DEPTH-1:0]   resolved_q, resolved_d;
  logic [ROB_DEPTH-1:0]   mispred_q, mispred_d;
  logic [31:0]            target_q [ROB_DEPTH];
  logic [31:0]            target_d [ROB_DEPTH];
  logic                   flush_q, flush_d;
  logic [31:0]            redirect_pc_q, redirect_pc_d;
  logic [31:0]            br_cnt_q, br_cnt_d;
  logic [31:0]            flush_cnt_q, flush_cnt_d;

  logic                   bypass;
  logic                   hit;
  logic                   hit_mispred;
  logic [31:0]            hit_target;
  logic                   commit_ready;
  logic                   fire;

  // A result landing on the bus in the same cycle the branch reaches the head counts as resolved
  always_comb begin
    bypass       = bus.br_cdb_valid && (bus.br_cdb_rob_id == bus.commit_rob_id);
    hit          = resolved_q[bus.commit_rob_id] || bypass;
    hit_mispred  = bypass ? bus.br_cdb_miss_predict   : mispred_q[bus.commit_rob_id];
    hit_target   = bypass ? bus.br_cdb_target_address : target_q[bus.commit_rob_id];
    commit_ready = !rst && bus.commit_valid && hit && (state_q == IDLE);
    fire         = bus.commit_valid && commit_ready;
  end

  always_comb begin
    resolved_d = resolved_q;
    mispred_d  = mispred_q;
    target_d   = target_q;
    if (state_q == FLUSH) begin
      resolved_d = '0;
    end else begin
      if (bus.br_cdb_valid) begin
        resolved_d[bus.br_cdb_rob_id] = 1'b1;
        mispred_d[bus.br_cdb_rob_id]  = bus.br_cdb_miss_predict;
        target_d[bus.br_cdb_rob_id]   = bus.br_cdb_target_address;
      end
      // Allocation is ordered after the CDB write so a same-index collision leaves it unresolved
      if (bus.alloc_valid) begin
        resolved_d[bus.alloc_rob_id] = 1'b0;
      end
      if (fire && !hit_mispred) begin
        resolved_d[bus.commit_rob_id] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rcnt_d        = rcnt_q;
    flush_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    br_cnt_d      = br_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          br_cnt_d = br_cnt_q + 32'd1;
          if (hit_mispred) begin
            state_d       = FLUSH;
            flush_d       = 1'b1;
            redirect_pc_d = hit_target;
            flush_cnt_d   = flush_cnt_q + 32'd1;
          end
        end
      end
      FLUSH: begin
        state_d = RECOVER;
        rcnt_d  = 4'(RECOVER_CYCLES - 1);
      end
      RECOVER: begin
        if (rcnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rcnt_q        <= 4'd0;
      resolved_q    <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= 32'd0;
      br_cnt_q      <= 32'd0;
      flush_cnt_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      rcnt_q        <= rcnt_d;
      resolved_q    <= resolved_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      br_cnt_q      <= br_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Payload fields are only meaningful while resolved is set, so they carry no reset
  always_ff @(posedge clk) begin
    mispred_q <= mispred_d;
    target_q  <= target_d;
  end

  assign bus.commit_ready       = commit_ready;
  assign bus.backend_flush      = flush_q;
  assign bus.redirect_valid     = flush_q;
  assign bus.redirect_pc        = redirect_pc_q;
  assign bus.perf_br_commit_cnt = br_cnt_q;
  assign bus.perf_flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed scenarios followed by random traffic, every cycle checked against a
// cycle-level reference model of the resolve unit kept in the bench.
module tb_br_resolve_unit;
  localparam int RC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  br_resolve_unit_if #(.ROB_DEPTH(16)) bif ();
  br_resolve_unit #(.ROB_DEPTH(16), .RECOVER_CYCLES(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int checks = 0;
  int errors = 0;

  // reference model: resolution table, blocking countdown, expected outputs
  bit          m_res [16];
  bit          m_mis [16];
  logic [31:0] m_tgt [16];
  int          block = 0;
  bit          m_flush = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_brc = 32'd0;
  logic [31:0] m_flc = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bif.br_cdb_valid = 1'b0;
    bif.br_cdb_rob_id = 4'd0;
    bif.br_cdb_miss_predict = 1'b0;
    bif.br_cdb_target_address = 32'd0;
    bif.alloc_valid = 1'b0;
    bif.alloc_rob_id = 4'd0;
    bif.commit_valid = 1'b0;
    bif.commit_rob_id = 4'd0;
  endtask

  task automatic cdb(input int id, input bit miss, input logic [31:0] tgt);
    bif.br_cdb_valid = 1'b1;
    bif.br_cdb_rob_id = 4'(id);
    bif.br_cdb_miss_predict = miss;
    bif.br_cdb_target_address = tgt;
  endtask

  task automatic commit(input int id);
    bif.commit_valid = 1'b1;
    bif.commit_rob_id = 4'(id);
  endtask

  // one clock: check commit_ready before the edge, advance model, check registered outputs
  task automatic cyc();
    int cid, aid, bid;
    bit byp, hit, mis, ready_exp, fire, in_flush;
    logic [31:0] tgt;
    #1;
    cid = int'(bif.commit_rob_id);
    aid = int'(bif.alloc_rob_id);
    bid = int'(bif.br_cdb_rob_id);
    byp = bif.br_cdb_valid && (bid == cid);
    hit = m_res[cid] || byp;
    mis = byp ? bif.br_cdb_miss_predict : m_mis[cid];
    tgt = byp ? bif.br_cdb_target_address : m_tgt[cid];
    ready_exp = !rst && bif.commit_valid && (block == 0) && hit;
    chk("commit_ready", {31'd0, bif.commit_ready}, {31'd0, ready_exp});
    fire = ready_exp;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_res[i] = 1'b0;
      block = 0; m_flush = 1'b0; m_pc = 32'd0; m_brc = 32'd0; m_flc = 32'd0;
    end else begin
      in_flush = (block == RC + 1);
      if (block > 0) block--;
      m_flush = 1'b0;
      if (in_flush) begin
        for (int i = 0; i < 16; i++) m_res[i] = 1'b0;
      end else begin
        if (bif.br_cdb_valid) begin
          m_res[bid] = 1'b1; m_mis[bid] = bif.br_cdb_miss_predict; m_tgt[bid] = bif.br_cdb_target_address;
        end
        if (bif.alloc_valid) m_res[aid] = 1'b0;
      end
      if (fire) begin
        m_brc++;
        if (mis) begin
          m_flc++; m_pc = tgt; m_flush = 1'b1; block = RC + 1;
        end else begin
          m_res[cid] = 1'b0;
        end
      end
    end
    #1;
    chk("backend_flush", {31'd0, bif.backend_flush}, {31'd0, m_flush});
    chk("redirect_valid", {31'd0, bif.redirect_valid}, {31'd0, m_flush});
    chk("redirect_pc", bif.redirect_pc, m_pc);
    chk("perf_br_commit_cnt", bif.perf_br_commit_cnt, m_brc);
    chk("perf_flush_cnt", bif.perf_flush_cnt, m_flc);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_res[i] = 1'b0; m_mis[i] = 1'b0; m_tgt[i] = 32'd0;
    end
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // unresolved head stays blocked
    commit(3);
    repeat (4) cyc();

    // normal resolve then commit
    idle_inputs(); bif.alloc_valid = 1'b1; bif.alloc_rob_id = 4'd5; cyc();
    idle_inputs(); cdb(5, 1'b0, 32'h0000_1000); cyc();
    idle_inputs(); commit(5); cyc();
    chk("dir_br_cnt_1", bif.perf_br_commit_cnt, 32'd1);

    // bypass mispredict, then hold commit through flush/recover
    idle_inputs(); cdb(7, 1'b1, 32'h8000_0040); commit(7); cyc();
    chk("dir_redirect_pc", bif.redirect_pc, 32'h8000_0040);
    idle_inputs(); commit(7);
    repeat (4) cyc();
    chk("dir_flush_cnt_1", bif.perf_flush_cnt, 32'd1);

    // back-to-back mispredicts: second one is cleared by the flush
    idle_inputs(); cdb(2, 1'b1, 32'h0000_2222); cyc();
    idle_inputs(); cdb(3, 1'b1, 32'h0000_3333); cyc();
    idle_inputs(); commit(2); cyc();
    idle_inputs(); commit(3);
    repeat (6) cyc();
    chk("dir_flush_cnt_2", bif.perf_flush_cnt, 32'd2);

    // alloc vs cdb collision on same and different indices
    idle_inputs(); bif.alloc_valid = 1'b1; bif.alloc_rob_id = 4'd4; cdb(4, 1'b0, 32'd4); cyc();
    idle_inputs(); commit(4); repeat (2) cyc();
    idle_inputs(); bif.alloc_valid = 1'b1; bif.alloc_rob_id = 4'd4; cdb(6, 1'b0, 32'd6); cyc();
    idle_inputs(); commit(6); cyc();

    // reset while recovering wipes the table and counters
    idle_inputs(); cdb(10, 1'b0, 32'hA); cyc();
    idle_inputs(); cdb(9, 1'b1, 32'h0000_9990); commit(9); cyc();
    idle_inputs(); cyc();
    idle_inputs(); cdb(11, 1'b0, 32'hB); cyc();
    idle_inputs(); rst = 1'b1; cyc();
    rst = 1'b0;
    chk("dir_rst_flush_cnt", bif.perf_flush_cnt, 32'd0);
    idle_inputs(); commit(10); cyc();
    idle_inputs(); commit(11); cyc();

    // random traffic over a narrow id range to force collisions and bypasses
    for (int n = 0; n < 800; n++) begin
      idle_inputs();
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1) cdb(int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bif.alloc_valid = 1'b1;
        bif.alloc_rob_id = 4'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 1) == 1) commit(int'($urandom_range(0, 7)));
      cyc();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/br_resolve_unit.md
Name: br_resolve_unit

Overview:
- Receiving end of the branch CDB. Captures every br_cdb broadcast (rob_id, miss_predict, target_address) into a per-ROB-entry resolution table.
- At ROB commit of a branch, gates retirement until the branch is resolved.
- On a committed mispredict, drives backend_flush and a frontend redirect, then holds a short recovery window.
- Sits between the branch FU, the ROB commit stage and the fetch PC mux.

Parameters:
- ROB_DEPTH, 16, number of ROB entries; table depth.
- ROB_IDX_W, $clog2(ROB_DEPTH), rob_id width.
- RECOVER_CYCLES, 2, cycles commit stays blocked after the flush cycle; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- br_cdb_valid  in  1  branch result broadcast valid
- br_cdb_rob_id  in  ROB_IDX_W  ROB entry of resolving branch
- br_cdb_miss_predict  in  1  branch mispredicted
- br_cdb_target_address  in  32  correct next PC
- alloc_valid  in  1  dispatch allocating a branch/AUIPC-free branch entry
- alloc_rob_id  in  ROB_IDX_W  entry being allocated
- commit_valid  in  1  ROB head is a branch requesting retirement
- commit_rob_id  in  ROB_IDX_W  ROB head index
- commit_ready  out  1  branch at head may retire this cycle
- backend_flush  out  1  one-cycle flush pulse to all backend structures
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  32  redirect target
- perf_br_commit_cnt  out  32  committed branches
- perf_flush_cnt  out  32  flushes issued

Behaviour:
- Table: per entry resolved (1b), mispred (1b), target (32b). Only the resolved bits are reset.
- Reset values:
  - All resolved bits = 0; state = IDLE.
  - backend_flush = redirect_valid = 0; redirect_pc = 0; both counters = 0.
  - commit_ready = 0.
- Table write rules:
  - alloc_valid: resolved[alloc_rob_id] <= 0.
  - br_cdb_valid: resolved <= 1, mispred <= br_cdb_miss_predict, target <= br_cdb_target_address.
  - Same index, same cycle: alloc wins.
  - Different indices: both writes apply.
- Commit check (combinational):
  - hit = resolved[commit_rob_id], OR a bypass when br_cdb_valid and br_cdb_rob_id == commit_rob_id (mispred/target taken from the bus).
  - commit_ready = commit_valid && hit && state==IDLE.
  - fire = commit_valid && commit_ready.
- FSM states IDLE, FLUSH, RECOVER:
  - IDLE:
    - fire with mispred=0: stay IDLE; perf_br_commit_cnt++; resolved[commit_rob_id] <= 0.
    - fire with mispred=1: next cycle state=FLUSH; redirect_pc <= target; perf_br_commit_cnt++; perf_flush_cnt++.
  - FLUSH: backend_flush=1 and redirect_valid=1 for exactly this one cycle (registered, latency 1 from fire).
    - All resolved bits cleared at end of cycle.
    - br_cdb and alloc inputs ignored this cycle.
    - Next state RECOVER; counter loaded with RECOVER_CYCLES-1.
  - RECOVER: commit_ready=0. br_cdb and alloc are accepted normally. Counter decrements; at 0, next state IDLE.
  - redirect_pc holds its value until the next mispredict fire.
- Boundaries:
  - Back-to-back mispredicts: the second commit is blocked until IDLE, so it cannot cause a double flush.
  - commit_valid with unresolved entry: commit_ready=0, no state change.
  - rob_id wrap-around: no special handling; index is a plain ROB_IDX_W field.
  - rst during FLUSH/RECOVER: returns to IDLE next cycle; outputs take reset values.
  - Counters wrap at 2^32.

Test Plan:
- Reset, then commit_valid=1, commit_rob_id=3, no resolution -> commit_ready=0 indefinitely; no flush.
- alloc id 5; br_cdb id 5, miss=0 in cycle t; commit id 5 at t+1 -> commit_ready=1, no flush, perf_br_commit_cnt=1.
- br_cdb id 7, miss=1, target 0x8000_0040 in the same cycle as commit id 7 (bypass) -> next cycle backend_flush=1, redirect_valid=1, redirect_pc=0x8000_0040, each for 1 cycle. commit_ready=0 for 1+RECOVER_CYCLES=3 cycles. perf_flush_cnt=1.
- Resolve ids 2 (miss=1) and 3 (miss=1); commit 2 -> flush. Commit 3 held during RECOVER and sees resolved=0 after flush (table cleared) -> no second flush.
- alloc id 4 and br_cdb id 4 in the same cycle -> entry stays unresolved; commit id 4 blocked. Separately, alloc id 4 with br_cdb id 6 -> id 6 resolved.
- Assert rst in RECOVER -> next cycle state IDLE, all outputs zero, counters 0, previously resolved entries unresolved.
